// File: rtl/mcpu_pkg.sv
// Shared definitions for the byte-stream accumulator core.
// Register indices, ALU ops, test conditions and sequencer states.
package mcpu_pkg;

    localparam logic [3:0] R_PC    = 4'd0;
    localparam logic [3:0] R_ADDR  = 4'd1;
    localparam logic [3:0] R_RAM   = 4'd2;
    localparam logic [3:0] R_A     = 4'd3;
    localparam logic [3:0] R_B     = 4'd4;
    localparam logic [3:0] R_ALU   = 4'd5;
    localparam logic [3:0] R_I     = 4'd6;
    localparam logic [3:0] R_J     = 4'd7;
    localparam logic [3:0] R_K     = 4'd8;
    localparam logic [3:0] R_X     = 4'd9;
    localparam logic [3:0] R_Y     = 4'd10;
    localparam logic [3:0] R_SENSE = 4'd11;

    localparam logic [3:0] OP_A   = 4'd0;
    localparam logic [3:0] OP_B   = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_NEG = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;

    localparam logic [3:0] C_EQ    = 4'd0;
    localparam logic [3:0] C_NE    = 4'd1;
    localparam logic [3:0] C_LTU   = 4'd2;
    localparam logic [3:0] C_GTU   = 4'd3;
    localparam logic [3:0] C_LTS   = 4'd4;
    localparam logic [3:0] C_AZ    = 4'd5;
    localparam logic [3:0] C_SENSE = 4'd6;
    localparam logic [3:0] C_ALUZ  = 4'd7;
    localparam logic [3:0] C_TRUE  = 4'd8;

    typedef enum logic [2:0] {
        S_FETCH,
        S_ALUI,
        S_MOVA,
        S_IMM0,
        S_IMM1,
        S_IMM2,
        S_IMM3,
        S_HALT
    } state_t;

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU operation and test-condition evaluation.
// Define MCPU_CORE_MUL_EN to give op 13 a 32-bit multiplier.
module mcpu_alu
    import mcpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] alu,
    input  logic [3:0]  op,
    input  logic [3:0]  cond,
    input  logic        sense,
    output logic [31:0] y,
    output logic        flag
);

    always_comb begin
        y = 32'd0;
        unique case (op)
            OP_A:   y = a;
            OP_B:   y = b;
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: y = a << b[4:0];
            OP_SHR: y = a >> b[4:0];
            OP_INC: y = a + 32'd1;
            OP_DEC: y = a - 32'd1;
            OP_NEG: y = 32'd0 - a;
`ifdef MCPU_CORE_MUL_EN
            OP_MUL: y = a * b;
`endif
            default: y = 32'd0;
        endcase
    end

    always_comb begin
        flag = 1'b0;
        unique case (cond)
            C_EQ:    flag = (a == b);
            C_NE:    flag = (a != b);
            C_LTU:   flag = (a < b);
            C_GTU:   flag = (a > b);
            C_LTS:   flag = ($signed(a) < $signed(b));
            C_AZ:    flag = (a == 32'd0);
            C_SENSE: flag = sense;
            C_ALUZ:  flag = (alu == 32'd0);
            C_TRUE:  flag = 1'b1;
            default: flag = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcpu_core.sv
// Byte-stream accumulator CPU: one ROM byte per clock, 32-bit regs.
// Optional multiplier for ALU op 13 via MCPU_CORE_MUL_EN.
module mcpu_core
    import mcpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sense,
    input  logic [7:0]  rom_value,
    output logic [31:0] rom_addr,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_in,
    output logic [31:0] ram_out,
    output logic        ram_we,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] i,
    output logic [31:0] j,
    output logic [31:0] k
);

    state_t      state, state_n;
    logic [31:0] pc, addr, ra, rb, ralu;
    logic [31:0] ri, rj, rk;
    logic        flag;
    logic        cnd_q;
    logic [3:0]  sub_q;
    logic [23:0] imm_q;

    logic        pc_adv, wr_en, alu_we, flag_we;
    logic        op_ld, imm_ld;
    logic [3:0]  wr_idx, alu_op;
    logic [31:0] wr_data, alu_b, src_val, alu_y;
    logic        cond_y;

    mcpu_alu u_alu (
        .a     (ra),
        .b     (alu_b),
        .alu   (ralu),
        .op    (alu_op),
        .cond  (rom_value[3:0]),
        .sense (sense),
        .y     (alu_y),
        .flag  (cond_y)
    );

    // PC reads as the address of the instruction after this one
    always_comb begin
        src_val = 32'd0;
        unique case (rom_value[7:4])
            R_PC:    src_val = pc + 32'd1;
            R_ADDR:  src_val = addr;
            R_RAM:   src_val = ram_in;
            R_A:     src_val = ra;
            R_B:     src_val = rb;
            R_ALU:   src_val = ralu;
            R_I:     src_val = ri;
            R_J:     src_val = rj;
            R_K:     src_val = rk;
            R_X:     src_val = x;
            R_Y:     src_val = y;
            R_SENSE: src_val = {31'd0, sense};
            default: src_val = 32'd0;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_adv  = 1'b1;
        wr_en   = 1'b0;
        wr_idx  = sub_q;
        wr_data = 32'd0;
        alu_we  = 1'b0;
        flag_we = 1'b0;
        alu_op  = sub_q;
        alu_b   = rb;
        op_ld   = 1'b0;
        imm_ld  = 1'b0;
        unique case (state)
            S_FETCH: begin
                op_ld = 1'b1;
                unique case (1'b1)
                    (rom_value == 8'h01):
                        state_n = S_HALT;
                    (rom_value[7:4] == 4'h1):
                        flag_we = 1'b1;
                    (rom_value[7:5] == 3'b010): begin
                        alu_we = 1'b1;
                        alu_op = rom_value[3:0];
                    end
                    (rom_value[7:5] == 3'b011):
                        state_n = S_ALUI;
                    (rom_value[7:6] == 2'b10 && rom_value[4:0] == 5'd0):
                        state_n = S_MOVA;
                    (rom_value[7:6] == 2'b11 && !rom_value[4]):
                        state_n = S_IMM0;
                    default: ;
                endcase
            end
            S_ALUI: begin
                alu_we  = 1'b1;
                alu_b   = sext8(rom_value);
                state_n = S_FETCH;
            end
            S_MOVA: begin
                wr_en   = !cnd_q || flag;
                wr_idx  = rom_value[3:0];
                wr_data = src_val;
                state_n = S_FETCH;
            end
            S_IMM0: begin
                imm_ld  = 1'b1;
                state_n = S_IMM1;
            end
            S_IMM1: begin
                imm_ld  = 1'b1;
                state_n = S_IMM2;
            end
            S_IMM2: begin
                imm_ld  = 1'b1;
                state_n = S_IMM3;
            end
            S_IMM3: begin
                wr_en   = !cnd_q || flag;
                wr_data = {rom_value, imm_q};
                state_n = S_FETCH;
            end
            S_HALT: pc_adv = 1'b0;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            pc    <= 32'd0;
            addr  <= 32'd0;
            ra    <= 32'd0;
            rb    <= 32'd0;
            ralu  <= 32'd0;
            ri    <= 32'd0;
            rj    <= 32'd0;
            rk    <= 32'd0;
            flag  <= 1'b0;
            cnd_q <= 1'b0;
            sub_q <= 4'd0;
            imm_q <= 24'd0;
        end else begin
            state <= state_n;
            if (wr_en && wr_idx == R_PC)
                pc <= wr_data;
            else if (pc_adv)
                pc <= pc + 32'd1;
            if (op_ld) begin
                cnd_q <= rom_value[5];
                sub_q <= rom_value[3:0];
            end
            // immediate bytes arrive LSB first; shift in from the top
            if (imm_ld)
                imm_q <= {rom_value, imm_q[23:8]};
            if (alu_we)
                ralu <= alu_y;
            if (flag_we)
                flag <= cond_y;
            if (wr_en) begin
                if (wr_idx == R_ADDR) addr <= wr_data;
                if (wr_idx == R_A)    ra   <= wr_data;
                if (wr_idx == R_B)    rb   <= wr_data;
                if (wr_idx == R_I)    ri   <= wr_data;
                if (wr_idx == R_J)    rj   <= wr_data;
                if (wr_idx == R_K)    rk   <= wr_data;
            end
        end
    end

    assign rom_addr = pc;
    assign ram_addr = addr;
    assign ram_out  = wr_data;
    assign ram_we   = wr_en && (wr_idx == R_RAM);
    assign i        = ri;
    assign j        = rj;
    assign k        = rk;

endmodule

// File: tb/tb_mcpu_core.sv
// Directed bench for mcpu_core: ROM/RAM models plus hand-computed checks.
module tb_mcpu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sense = 1'b0;
    logic [7:0]  rom_value;
    logic [31:0] rom_addr, ram_addr, ram_in, ram_out;
    logic        ram_we;
    logic [31:0] x = 32'h0012_3456;
    logic [31:0] y = 32'd0;
    logic [31:0] i, j, k;

    logic [7:0]  rom [0:255];
    logic [31:0] ram [0:15];
    int          checks = 0;
    int          failures = 0;
    int          we_cnt = 0;
    logic [31:0] mul_exp;

    mcpu_core dut (
        .clk       (clk),
        .reset     (reset),
        .sense     (sense),
        .rom_value (rom_value),
        .rom_addr  (rom_addr),
        .ram_addr  (ram_addr),
        .ram_in    (ram_in),
        .ram_out   (ram_out),
        .ram_we    (ram_we),
        .x         (x),
        .y         (y),
        .i         (i),
        .j         (j),
        .k         (k)
    );

    always #5 clk = ~clk;

    assign rom_value = rom[rom_addr[7:0]];
    assign ram_in    = ram[ram_addr[3:0]];

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr[3:0]] <= ram_out;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [31:0] a);
        int n;
        n = 0;
        while (rom_addr !== a && n < 300) begin
            step(1);
            n++;
        end
        if (rom_addr !== a) begin
            checks++;
            failures++;
            $error("FAIL timeout obs=%0h exp=%0h", rom_addr, a);
        end
    endtask

    initial begin
        for (int n = 0; n < 256; n++) rom[n] = 8'h00;
        for (int n = 0; n < 16; n++) ram[n] = 32'd0;
        // 0: IMOV A=0x800 ; 5: MOV A->I ; 7: IMOV ADDR=0x800
        rom[0] = 8'hC3; rom[1] = 8'h00; rom[2] = 8'h08; rom[3] = 8'h00; rom[4] = 8'h00;
        rom[5] = 8'h80; rom[6] = 8'h36;
        rom[7] = 8'hC1; rom[8] = 8'h00; rom[9] = 8'h08; rom[10] = 8'h00; rom[11] = 8'h00;
        // 12: IMOV RAM=0x71247 ; 17: IMOV A=-1 ; 22: ALU=A+1 ; 24: TEST 7
        rom[12] = 8'hC2; rom[13] = 8'h47; rom[14] = 8'h12; rom[15] = 8'h07; rom[16] = 8'h00;
        rom[17] = 8'hC3; rom[18] = 8'hFF; rom[19] = 8'hFF; rom[20] = 8'hFF; rom[21] = 8'hFF;
        rom[22] = 8'h72; rom[23] = 8'h01;
        rom[24] = 8'h17;
        // 25: CIMOV I=0x11 ; 30: TEST 15 (false) ; 31: CIMOV I=0x22
        rom[25] = 8'hE6; rom[26] = 8'h11; rom[27] = 8'h00; rom[28] = 8'h00; rom[29] = 8'h00;
        rom[30] = 8'h1F;
        rom[31] = 8'hE6; rom[32] = 8'h22; rom[33] = 8'h00; rom[34] = 8'h00; rom[35] = 8'h00;
        // 36: A=0xf80 ; 41: B=0xf80 ; 46: J=0x60 ; 51: TEST 0 ; 52: CMOV J->PC
        rom[36] = 8'hC3; rom[37] = 8'h80; rom[38] = 8'h0F; rom[39] = 8'h00; rom[40] = 8'h00;
        rom[41] = 8'hC4; rom[42] = 8'h80; rom[43] = 8'h0F; rom[44] = 8'h00; rom[45] = 8'h00;
        rom[46] = 8'hC7; rom[47] = 8'h60; rom[48] = 8'h00; rom[49] = 8'h00; rom[50] = 8'h00;
        rom[51] = 8'h10;
        rom[52] = 8'hA0; rom[53] = 8'h70;
        // 96: B=0xf81 ; 101: TEST 0 ; 102: CMOV J->PC (not taken)
        rom[96] = 8'hC4; rom[97] = 8'h81; rom[98] = 8'h0F; rom[99] = 8'h00; rom[100] = 8'h00;
        rom[101] = 8'h10;
        rom[102] = 8'hA0; rom[103] = 8'h70;
        // 104: MOV X->K ; 106: ADD ; 107: MOV ALU->J ; 109: MUL ; 110: MOV ALU->J
        rom[104] = 8'h80; rom[105] = 8'h98;
        rom[106] = 8'h42;
        rom[107] = 8'h80; rom[108] = 8'h57;
        rom[109] = 8'h4D;
        rom[110] = 8'h80; rom[111] = 8'h57;
        // 112: SUB imm -1 ; 114: MOV ALU->I ; 116: MOV PC->K ; 118: HALT
        rom[112] = 8'h73; rom[113] = 8'hFF;
        rom[114] = 8'h80; rom[115] = 8'h56;
        rom[116] = 8'h80; rom[117] = 8'h08;
        rom[118] = 8'h01;
`ifdef MCPU_CORE_MUL_EN
        mul_exp = 32'h00F0_4F80;
`else
        mul_exp = 32'd0;
`endif

        #12 reset = 1'b1;
        step(2);
        reset = 1'b0;
        #1;
        chk("rst_pc", rom_addr, 32'd0);
        chk("rst_i", i, 32'd0);
        chk("rst_jk", j | k, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        step(5);
        chk("imov_pc", rom_addr, 32'd5);
        run_to(32'd7);
        chk("mov_a_i", i, 32'h800);

        run_to(32'd16);
        chk("ram_we", {31'd0, ram_we}, 32'd1);
        chk("ram_addr", ram_addr, 32'h800);
        chk("ram_out", ram_out, 32'h0007_1247);
        step(1);
        chk("ram_data", ram[0], 32'h0007_1247);

        run_to(32'd30);
        chk("cimov_t", i, 32'h11);
        run_to(32'd36);
        chk("cimov_f", i, 32'h11);

        run_to(32'd53);
        step(1);
        chk("cmov_jump", rom_addr, 32'h60);
        run_to(32'd103);
        step(1);
        chk("cmov_fall", rom_addr, 32'd104);

        run_to(32'd106);
        chk("mov_x_k", k, 32'h0012_3456);
        run_to(32'd109);
        chk("alu_add", j, 32'h1F01);
        run_to(32'd112);
        chk("alu_mul", j, mul_exp);
        run_to(32'd116);
        chk("alu_subi", i, 32'hF81);
        run_to(32'd118);
        chk("mov_pc_k", k, 32'd118);

        run_to(32'd119);
        step(20);
        chk("halt_pc", rom_addr, 32'd119);
        chk("halt_we", we_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
